mantenimiento_planificador: RTL and testbench
=============================================

# mantenimiento_planificador

Round-robin scheduler that shares the single maintenance unit among `N_REQ` requesting machines. It grants the unit to one requester at a time and drives the unit's start/stop handshake (`mnt_iniciar`, `mnt_detener`, `mnt_terminado`). It holds the unit in maintenance for the requester's programmed duration, then reports completion or a timeout. It sits between the machine controllers and the maintenance FSM.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DUR_W`, 8: width of each per-requester duration field.
- `TIMEOUT`, 16: max cycles to wait for `mnt_terminado` after asserting `mnt_detener` (≥2).
- `clk` in 1: clock; all logic on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: level request per requester; held until its `done`.
- `req_dur` in N_REQ*DUR_W: packed durations; requester i is bits [i*DUR_W +: DUR_W].
- `mnt_terminado` in 1: unit's completion flag.
- `clr_error` in 1: synchronous clear of `error`.
- `mnt_iniciar` out 1: start pulse to the unit.
- `mnt_detener` out 1: stop level to the unit.
- `grant` out N_REQ: one-hot owner of the unit, else 0.
- `done` out N_REQ: one-cycle completion pulse to the owner.
- `busy` out 1: high in any state other than IDLE.
- `error` out 1: sticky timeout flag.
- `served_cnt` out 8: count of successful services, wraps 255→0.

## Operation
- States: IDLE, START, RUN, STOP, DONE.
- IDLE: if `req`≠0, select the first set bit scanning upward from `rr_ptr` with wrap. Latch its index `sel` and duration `dur = req_dur[sel]`; dur==0 is treated as 1. Go to START. If `req`==0, stay.
- START: `mnt_iniciar`=1 for exactly this cycle; `cnt`←dur; go to RUN.
- RUN: `cnt` decrements each cycle; leave for STOP on the cycle `cnt`==1. RUN lasts exactly dur cycles.
- STOP: `mnt_detener`=1 and wait timer increments each cycle.
  - `mnt_terminado`=1 → DONE.
  - Timer reaches TIMEOUT without `mnt_terminado` → set `error`, `rr_ptr`←(sel+1) mod N_REQ, go to IDLE. No `done` pulse, `served_cnt` unchanged.
- DONE: `done[sel]`=1 for one cycle; `served_cnt`++; `rr_ptr`←(sel+1) mod N_REQ; go to IDLE.
- `grant[sel]`=1 in START, RUN, STOP and DONE; `grant`=0 in IDLE.
- `req` is sampled only in IDLE. Deassertion mid-service is ignored: the service completes and `done` still pulses. A requester that holds `req` after `done` is re-served after higher-rotation requesters.
- `mnt_terminado` is ignored outside STOP.
- `error`: set on timeout, cleared by `clr_error`; set wins if both happen in the same cycle.
- Reset (any state, including mid-RUN or mid-STOP) → IDLE, `rr_ptr`=0, `cnt`=0, timer=0, `served_cnt`=0, `error`=0. All outputs drop to 0 immediately (asynchronous); the unit is not sent `mnt_detener`.

## Timing
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- Reset values: `mnt_iniciar`=0, `mnt_detener`=0, `grant`=0, `done`=0, `busy`=0, `error`=0, `served_cnt`=0.
- `req` seen in IDLE at edge k → `grant`, `busy` and `mnt_iniciar` high during cycle k+1 (START).
- RUN occupies cycles k+2 .. k+1+dur; `mnt_detener` rises in cycle k+2+dur.
- `mnt_terminado` sampled high at STOP edge m → `done` high in cycle m+1, `mnt_detener` low in cycle m+1; IDLE at m+2.
- Minimum back-to-back service period: dur+4 cycles (START, RUN×dur, STOP×1, DONE, IDLE).
- Timeout path: `error` is high and state is IDLE in the cycle after the TIMEOUT-th STOP cycle.

## Test plan
- Single request: `req`=0001, dur=3, `mnt_terminado` 2 cycles after `mnt_detener` → `mnt_iniciar` 1 cycle, 3 RUN cycles, `done`=0001 pulse, `served_cnt`=1.
- Round robin: `req`=1111 held, all dur=1 → grant order 0001,0010,0100,1000,0001; each `done` exactly once per rotation.
- Zero duration: requester 2, dur=0 → behaves exactly as dur=1 (one RUN cycle).
- Timeout: never assert `mnt_terminado`, TIMEOUT=16 → `error`=1 after 16 STOP cycles, no `done`, `served_cnt` unchanged, next grant goes to sel+1; `clr_error` clears it.
- Reset mid-RUN: deassert `reset_n` in RUN → all outputs 0 asynchronously; after release, `req`=0100 is served first with `rr_ptr`=0.
- Wrap: 256 successful services → `served_cnt` returns to 0; `req` dropped mid-service still yields `done`.

Source files
------------

// File: rtl/mantenimiento_planificador.sv
// Round-robin scheduler that shares one maintenance unit among N_REQ machines.
// It drives the start/stop handshake and reports completion or a timeout.
module mantenimiento_planificador #(
    parameter int N_REQ   = 4,
    parameter int DUR_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DUR_W-1:0] req_dur,
    input  logic                   mnt_terminado,
    input  logic                   clr_error,
    output logic                   mnt_iniciar,
    output logic                   mnt_detener,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   error,
    output logic [7:0]             served_cnt
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_sel_inc;
    logic             w_found;
    logic [DUR_W-1:0] r_dur;
    logic [DUR_W-1:0] r_cnt;
    logic [DUR_W-1:0] w_pick_dur;
    logic [DUR_W-1:0] w_durs [N_REQ];
    logic [TMR_W-1:0] r_timer;
    logic             w_timeout;
    logic [7:0]       r_served_cnt;
    logic             r_error;
    logic [N_REQ-1:0] w_sel_onehot;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_durs[i] = req_dur[i*DUR_W +: DUR_W];
        end
    end

    // First pending requester at or after the rotation pointer, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_found = 1'b0;
        w_pick  = '0;
        for (int off = 0; off < N_REQ; off++) begin
            int idx;
            idx = int'(r_rr_ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(idx);
            end
        end
    end

    assign w_pick_dur = w_durs[w_pick];
    assign w_sel_inc  = (r_sel == IDX_W'(N_REQ - 1)) ? '0 : r_sel + IDX_W'(1);
    assign w_timeout  = (r_state == S_STOP) && !mnt_terminado
                        && (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_START;
            S_START: w_next = S_RUN;
            S_RUN:   if (r_cnt == DUR_W'(1)) w_next = S_STOP;
            S_STOP: begin
                if (mnt_terminado) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel        <= '0;
            r_rr_ptr     <= '0;
            r_dur        <= '0;
            r_cnt        <= '0;
            r_timer      <= '0;
            r_served_cnt <= '0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel <= w_pick;
                        r_dur <= (w_pick_dur == '0) ? DUR_W'(1) : w_pick_dur;
                    end
                end
                S_START: begin
                    r_cnt   <= r_dur;
                    r_timer <= '0;
                end
                S_RUN: r_cnt <= r_cnt - DUR_W'(1);
                S_STOP: begin
                    if (mnt_terminado || w_timeout) begin
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                    if (w_timeout) begin
                        r_rr_ptr <= w_sel_inc;
                    end
                end
                S_DONE: begin
                    r_served_cnt <= r_served_cnt + 8'd1;
                    r_rr_ptr     <= w_sel_inc;
                end
                default: ;
            endcase

            // A timeout in the same cycle as a clear leaves the flag set.
            if (w_timeout) begin
                r_error <= 1'b1;
            end else if (clr_error) begin
                r_error <= 1'b0;
            end
        end
    end

    assign w_sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_sel;

    assign mnt_iniciar = (r_state == S_START);
    assign mnt_detener = (r_state == S_STOP);
    assign busy        = (r_state != S_IDLE);
    assign grant       = (r_state != S_IDLE) ? w_sel_onehot : '0;
    assign done        = (r_state == S_DONE) ? w_sel_onehot : '0;
    assign error       = r_error;
    assign served_cnt  = r_served_cnt;

endmodule

// File: tb/tb_mantenimiento_planificador.sv
// Scoreboard bench for mantenimiento_planificador: expected grants and completions
// are queued as stimulus is applied and matched as the DUT produces them.
module tb_mantenimiento_planificador;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk;
    logic          reset_n;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_dur;
    logic          mnt_terminado;
    logic          clr_error;
    logic          mnt_iniciar;
    logic          mnt_detener;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          busy;
    logic          error;
    logic [7:0]    served_cnt;

    mantenimiento_planificador #(.N_REQ(N), .DUR_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_dur       (req_dur),
        .mnt_terminado (mnt_terminado),
        .clr_error     (clr_error),
        .mnt_iniciar   (mnt_iniciar),
        .mnt_detener   (mnt_detener),
        .grant         (grant),
        .done          (done),
        .busy          (busy),
        .error         (error),
        .served_cnt    (served_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] vec;
        int           run;
    } gexp_t;

    typedef struct {
        logic [N-1:0] vec;
        int           served;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int model_served = 0;
    int term_delay   = 1;
    bit respond      = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_service(input logic [N-1:0] vec, input int dur, input bit ok);
        gq.push_back('{vec: vec, run: (dur == 0) ? 1 : dur});
        if (ok) begin
            model_served = (model_served + 1) % 256;
            dq.push_back('{vec: vec, served: model_served});
        end
    endtask

    task automatic wait_iniciar();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mnt_iniciar && n < 300);
        check("wait_iniciar", 32'(mnt_iniciar), 32'd1);
    endtask

    task automatic wait_detener();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mnt_detener && n < 300);
        check("wait_detener", 32'(mnt_detener), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < 300);
        check("wait_done", 32'(done != '0), 32'd1);
    endtask

    task automatic apply_reset();
        check("queues_drained", 32'(gq.size() + dq.size()), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clk);
        gq.delete();
        dq.delete();
        model_served = 0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Maintenance unit model: raises mnt_terminado term_delay cycles into the stop request.
    int det_cycles = 0;
    initial begin
        mnt_terminado = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n || !mnt_detener || !respond) begin
                det_cycles    = 0;
                mnt_terminado = 1'b0;
            end else begin
                det_cycles++;
                mnt_terminado = (det_cycles >= term_delay);
            end
        end
    end

    // Output monitor: matches grants, RUN lengths, done pulses and the served count.
    gexp_t cur;
    dexp_t dcur;
    bit    cur_valid   = 1'b0;
    bit    cnt_pending = 1'b0;
    bit    prev_det    = 1'b0;
    int    run_len     = 0;
    int    exp_served  = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            cur_valid   = 1'b0;
            cnt_pending = 1'b0;
            prev_det    = 1'b0;
            run_len     = 0;
        end else begin
            if (cnt_pending) begin
                check("served_cnt", 32'(served_cnt), 32'(exp_served));
                check("done_width", 32'(done), 32'd0);
                cnt_pending = 1'b0;
            end
            if (mnt_iniciar) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", 32'(grant), 32'd0);
                end else begin
                    cur       = gq.pop_front();
                    cur_valid = 1'b1;
                    run_len   = 0;
                    check("grant", 32'(grant), 32'(cur.vec));
                end
            end else if (busy && !mnt_detener && done == '0) begin
                run_len++;
            end
            if (mnt_detener && !prev_det && cur_valid) begin
                check("run_len", 32'(run_len), 32'(cur.run));
            end
            prev_det = mnt_detener;
            if (done != '0) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    dcur        = dq.pop_front();
                    exp_served  = dcur.served;
                    cnt_pending = 1'b1;
                    check("done", 32'(done), 32'(dcur.vec));
                end
            end
        end
    end

    initial begin
        int stop_n;

        reset_n   = 1'b0;
        req       = '0;
        req_dur   = '0;
        clr_error = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_iniciar", 32'(mnt_iniciar), 32'd0);
        check("rst_detener", 32'(mnt_detener), 32'd0);
        check("rst_grant",   32'(grant),       32'd0);
        check("rst_done",    32'(done),        32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_error",   32'(error),       32'd0);
        check("rst_served",  32'(served_cnt),  32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single request, dur=3, unit completes 2 cycles into the stop request
        term_delay = 2;
        req_dur    = '0;
        req_dur[0*DW +: DW] = 8'd3;
        push_service(4'b0001, 3, 1'b1);
        req = 4'b0001;
        @(negedge clk);
        check("start_iniciar", 32'(mnt_iniciar), 32'd1);
        check("start_grant",   32'(grant),       32'b0001);
        check("start_busy",    32'(busy),        32'd1);
        @(negedge clk);
        check("iniciar_pulse", 32'(mnt_iniciar), 32'd0);
        wait_done();
        req = '0;
        repeat (2) @(negedge clk);
        check("single_served", 32'(served_cnt), 32'd1);
        check("single_idle",   32'(busy),       32'd0);

        // Round robin from rr_ptr=0, all durations 1
        apply_reset();
        term_delay = 1;
        req_dur    = {4{8'd1}};
        push_service(4'b0001, 1, 1'b1);
        push_service(4'b0010, 1, 1'b1);
        push_service(4'b0100, 1, 1'b1);
        push_service(4'b1000, 1, 1'b1);
        push_service(4'b0001, 1, 1'b1);
        req = 4'b1111;
        repeat (5) wait_done();
        req = '0;
        repeat (2) @(negedge clk);

        // Zero duration on requester 2 behaves as one RUN cycle
        req_dur = '0;
        push_service(4'b0100, 0, 1'b1);
        req = 4'b0100;
        wait_done();
        req = '0;
        repeat (2) @(negedge clk);

        // Timeout on requester 1: no done, count unchanged, next grant rotates past it
        respond = 1'b0;
        req_dur = '0;
        req_dur[1*DW +: DW] = 8'd2;
        push_service(4'b0010, 2, 1'b0);
        req = 4'b0010;
        wait_detener();
        stop_n = 0;
        while (mnt_detener && stop_n < 100) begin
            stop_n++;
            @(negedge clk);
        end
        check("stop_cycles",     32'(stop_n),     32'(TO));
        check("timeout_error",   32'(error),      32'd1);
        check("timeout_idle",    32'(busy),       32'd0);
        check("timeout_served",  32'(served_cnt), 32'(model_served));
        respond = 1'b1;
        req_dur = {4{8'd1}};
        push_service(4'b0100, 1, 1'b1);
        req = 4'b1111;
        wait_done();
        req = '0;
        @(negedge clk);
        check("error_sticky", 32'(error), 32'd1);
        clr_error = 1'b1;
        @(negedge clk);
        clr_error = 1'b0;
        check("error_cleared", 32'(error), 32'd0);

        // Timeout while clr_error is held: the set wins, then the clear takes effect
        respond   = 1'b0;
        clr_error = 1'b1;
        push_service(4'b0010, 1, 1'b0);
        req = 4'b0010;
        wait_detener();
        stop_n = 0;
        while (mnt_detener && stop_n < 100) begin
            stop_n++;
            @(negedge clk);
        end
        check("set_wins_error", 32'(error), 32'd1);
        req = '0;
        @(negedge clk);
        check("held_clr_clears", 32'(error), 32'd0);
        clr_error = 1'b0;
        respond   = 1'b1;

        // Asynchronous reset in the middle of RUN
        req_dur = '0;
        req_dur[2*DW +: DW] = 8'd10;
        push_service(4'b0100, 10, 1'b0);
        req = 4'b0100;
        wait_iniciar();
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_iniciar", 32'(mnt_iniciar), 32'd0);
        check("arst_detener", 32'(mnt_detener), 32'd0);
        check("arst_grant",   32'(grant),       32'd0);
        check("arst_busy",    32'(busy),        32'd0);
        check("arst_served",  32'(served_cnt),  32'd0);
        req = '0;
        check("arst_queues", 32'(gq.size() + dq.size()), 32'd0);
        model_served = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        req_dur = {4{8'd2}};
        push_service(4'b0001, 2, 1'b1);
        push_service(4'b0100, 2, 1'b1);
        req = 4'b0101;
        wait_done();
        req = 4'b0100;
        wait_done();
        req = '0;
        repeat (2) @(negedge clk);

        // 256 services wrap served_cnt; the last one loses its req mid-service
        apply_reset();
        term_delay = 1;
        req_dur    = '0;
        for (int i = 0; i < 256; i++) begin
            push_service(4'b0001 << (i % 4), 0, 1'b1);
        end
        req = 4'b1111;
        repeat (255) wait_done();
        wait_iniciar();
        @(negedge clk);
        req = '0;
        wait_done();
        repeat (2) @(negedge clk);
        check("wrap_served", 32'(served_cnt), 32'd0);
        check("grant_q_empty", 32'(gq.size()), 32'd0);
        check("done_q_empty",  32'(dq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
